// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/response bus
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multi-cycle fetch stage: PC, instruction register, next-PC select
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   imem,
    output logic                 instr_valid,
    output logic [31:0]          Instr,
    output logic [5:0]           OpCode,
    output logic [5:0]           Funct,
    output logic [31:0]          PC,
    input  logic                 instr_ack,
    input  logic                 Branch,
    input  logic                 Jump,
    input  logic                 BrTaken,
    output logic [CNT_W-1:0]     fetch_cnt
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        capture;
    logic        retire;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: if (imem.imem_ready) state_nxt = S_HOLD;
            S_HOLD:  if (instr_ack)       state_nxt = S_FETCH;
            default: state_nxt = S_BOOT;
        endcase
    end

    // Request and valid are pure state decodes so an async reset drops them at once.
    always_comb begin
        imem.imem_req  = 1'b0;
        instr_valid    = 1'b0;
        capture        = 1'b0;
        retire         = 1'b0;
        case (state)
            S_FETCH: begin
                imem.imem_req = 1'b1;
                capture       = imem.imem_ready;
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                retire      = instr_ack;
            end
            default: ;
        endcase
    end

    assign imem.imem_addr = PC;

    assign OpCode = Instr[31:26];
    assign Funct  = Instr[5:0];

    // Jump wins over Branch because the J encoding raises both control lines.
    always_comb begin
        pc4        = PC + 32'd4;
        br_off     = {{14{Instr[15]}}, Instr[15:0], 2'b00};
        br_target  = pc4 + br_off;
        jmp_target = {pc4[31:28], Instr[25:0], 2'b00};
        if (Jump) begin
            next_pc = jmp_target;
        end else if (Branch && BrTaken) begin
            next_pc = br_target;
        end else begin
            next_pc = pc4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC        <= {RESET_PC[31:2], 2'b00};
            Instr     <= 32'h0000_0000;
            fetch_cnt <= '0;
        end else begin
            if (capture) begin
                Instr <= imem.imem_rdata;
            end
            if (retire) begin
                PC        <= {next_pc[31:2], 2'b00};
                fetch_cnt <= fetch_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus2 ();

    logic        instr_valid, instr_ack, Branch, Jump, BrTaken;
    logic [31:0] Instr, PC;
    logic [5:0]  OpCode, Funct;
    logic [15:0] fetch_cnt;

    logic        valid2, ack2, br2, jmp2, tk2;
    logic [31:0] instr2, pc2;
    logic [5:0]  op2, fn2;
    logic [7:0]  cnt2;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .instr_valid (instr_valid),
        .Instr       (Instr),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .PC          (PC),
        .instr_ack   (instr_ack),
        .Branch      (Branch),
        .Jump        (Jump),
        .BrTaken     (BrTaken),
        .fetch_cnt   (fetch_cnt)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(8)) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus2),
        .instr_valid (valid2),
        .Instr       (instr2),
        .OpCode      (op2),
        .Funct       (fn2),
        .PC          (pc2),
        .instr_ack   (ack2),
        .Branch      (br2),
        .Jump        (jmp2),
        .BrTaken     (tk2),
        .fetch_cnt   (cnt2)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_cnt = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] word, input int waits);
        logic [31:0] ea;
        int guard;
        guard = 0;
        while (bus.imem_req !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("fetch_req", {31'd0, bus.imem_req}, 32'd1);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_empty: observed addr %h expected none", bus.imem_addr);
            ea = 32'hxxxx_xxxx;
        end else begin
            ea = exp_q.pop_front();
        end
        check("fetch_addr", bus.imem_addr, ea);
        for (int w = 0; w < waits; w++) begin
            bus.imem_ready = 1'b0;
            @(negedge clk);
            check("wait_req", {31'd0, bus.imem_req}, 32'd1);
            check("wait_addr", bus.imem_addr, ea);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        bus.imem_rdata = word;
        bus.imem_ready = 1'b1;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_instr", Instr, word);
        check("hold_opcode", {26'd0, OpCode}, {26'd0, word[31:26]});
        check("hold_funct", {26'd0, Funct}, {26'd0, word[5:0]});
        check("hold_pc", PC, ea);
        check("hold_req", {31'd0, bus.imem_req}, 32'd0);
    endtask

    task automatic do_ack(input logic br, input logic jmp, input logic tk, input logic [31:0] nxt);
        exp_q.push_back(nxt);
        exp_cnt = exp_cnt + 16'd1;
        Branch    = br;
        Jump      = jmp;
        BrTaken   = tk;
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        Branch    = 1'b0;
        Jump      = 1'b0;
        BrTaken   = 1'b0;
        check("ack_valid", {31'd0, instr_valid}, 32'd0);
        check("ack_req", {31'd0, bus.imem_req}, 32'd1);
        check("ack_cnt", {16'd0, fetch_cnt}, {16'd0, exp_cnt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        instr_ack = 1'b0; Branch = 1'b0; Jump = 1'b0; BrTaken = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        bus2.imem_ready = 1'b0;
        bus2.imem_rdata = 32'h0;
        ack2 = 1'b0; br2 = 1'b0; jmp2 = 1'b0; tk2 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", PC, 32'h0000_3000);
        check("rst_instr", Instr, 32'h0);
        check("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
        check("rst_opcode", {26'd0, OpCode}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0000_3000);

        exp_q.push_back(32'h0000_3000);
        rst_n = 1'b1;
        check("boot_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        check("boot_no_capture", Instr, 32'h0);
        check("boot_valid", {31'd0, instr_valid}, 32'd0);
        do_fetch(32'h0000_0000, 0);

        // ready and control lines without ack in HOLD must be ignored
        bus.imem_rdata = 32'hFFFF_FFFF;
        bus.imem_ready = 1'b1;
        Branch = 1'b1; Jump = 1'b1; BrTaken = 1'b1;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        Branch = 1'b0; Jump = 1'b0; BrTaken = 1'b0;
        check("stray_rdy_instr", Instr, 32'h0);
        check("stray_rdy_valid", {31'd0, instr_valid}, 32'd1);
        check("stray_rdy_pc", PC, 32'h0000_3000);
        check("stray_rdy_cnt", {16'd0, fetch_cnt}, 32'd0);

        do_ack(1'b0, 1'b0, 1'b0, 32'h0000_3004);
        do_fetch(32'h0000_0020, 3);
        do_ack(1'b0, 1'b0, 1'b0, 32'h0000_3008);
        do_fetch(32'h1000_FFFE, 0);
        do_ack(1'b1, 1'b0, 1'b1, 32'h0000_3004);
        do_fetch(32'h1000_FFFE, 1);
        do_ack(1'b0, 1'b0, 1'b1, 32'h0000_3008);
        do_fetch(32'h1000_FFFE, 0);
        do_ack(1'b1, 1'b0, 1'b0, 32'h0000_300C);
        do_fetch(32'h0000_0000, 2);
        do_ack(1'b0, 1'b0, 1'b0, 32'h0000_3010);
        do_fetch(32'h0800_0C00, 0);
        do_ack(1'b1, 1'b1, 1'b0, 32'h0000_3000);
        do_fetch(32'h1000_0004, 0);
        do_ack(1'b1, 1'b0, 1'b1, 32'h0000_3014);

        // ack while fetching must not move the PC or count
        instr_ack = 1'b1; Branch = 1'b1; Jump = 1'b1; BrTaken = 1'b1;
        repeat (2) @(negedge clk);
        instr_ack = 1'b0; Branch = 1'b0; Jump = 1'b0; BrTaken = 1'b0;
        check("stray_ack_req", {31'd0, bus.imem_req}, 32'd1);
        check("stray_ack_addr", bus.imem_addr, 32'h0000_3014);
        check("stray_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("stray_ack_cnt", {16'd0, fetch_cnt}, {16'd0, exp_cnt});

        rst_n = 1'b0;
        #1;
        check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_pc", PC, 32'h0000_3000);
        check("midrst_cnt", {16'd0, fetch_cnt}, 32'd0);
        check("midrst_instr", Instr, 32'h0);
        exp_q.delete();
        exp_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(32'h0000_3000);
        @(negedge clk);
        do_fetch(32'h0000_0020, 0);
        do_ack(1'b0, 1'b0, 1'b0, 32'h0000_3004);

        check("wrap_start_req", {31'd0, bus2.imem_req}, 32'd1);
        check("wrap_start_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        bus2.imem_ready = 1'b1;
        @(negedge clk);
        bus2.imem_ready = 1'b0;
        check("wrap_valid", {31'd0, valid2}, 32'd1);
        check("wrap_pc", pc2, 32'hFFFF_FFFC);
        ack2 = 1'b1;
        @(negedge clk);
        ack2 = 1'b0;
        check("wrap_addr", bus2.imem_addr, 32'h0);
        check("wrap_req", {31'd0, bus2.imem_req}, 32'd1);
        check("wrap_cnt1", {24'd0, cnt2}, 32'd1);

        bus2.imem_ready = 1'b1;
        ack2 = 1'b1;
        repeat (2 * 254) @(negedge clk);
        check("cnt_max", {24'd0, cnt2}, 32'h0000_00FF);
        check("cnt_max_addr", bus2.imem_addr, 32'h0000_03F8);
        repeat (2) @(negedge clk);
        bus2.imem_ready = 1'b0;
        ack2 = 1'b0;
        check("cnt_wrap", {24'd0, cnt2}, 32'd0);
        check("cnt_wrap_addr", bus2.imem_addr, 32'h0000_03FC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage. Holds the program counter, fetches one word per instruction from instruction memory through a req/ready handshake, and holds it in an instruction register. It presents OpCode/Funct/immediate fields to the decode/control stage. On decode acknowledge it computes the next PC (sequential, branch or jump) from the Branch/Jump/taken feedback. Sits directly upstream of the control decoder; multi-cycle, one instruction in flight.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
CNT_W, 16, width of retired-fetch counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word address of request (= PC)
imem_ready  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_ready
instr_valid  out  1  IR holds a fetched instruction
Instr  out  32  instruction register
OpCode  out  6  Instr[31:26]
Funct  out  6  Instr[5:0]
PC  out  32  address of instruction in IR
instr_ack  in  1  decode/execute done with current instruction
Branch  in  1  control: instruction is branch (sampled with instr_ack)
Jump  in  1  control: instruction is jump (sampled with instr_ack)
BrTaken  in  1  ALU branch condition true (sampled with instr_ack)
fetch_cnt  out  CNT_W  number of acknowledged instructions, wraps

Behaviour:
- Reset (async, rst_n=0): state=BOOT, PC=RESET_PC, Instr=0, instr_valid=0, imem_req=0, fetch_cnt=0. All outputs take reset values immediately, including mid-handshake.
- States: BOOT, FETCH, HOLD.
- BOOT: lasts exactly one cycle after reset release -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=PC; both held stable until imem_ready.
  - On imem_ready: Instr<=imem_rdata, instr_valid<=1 -> HOLD.
  - Same-cycle ready permitted (zero wait states): data is visible one cycle after req rises.
- HOLD:
  - imem_req=0; Instr and PC stable.
  - On instr_ack: instr_valid<=0, fetch_cnt<=fetch_cnt+1 (mod 2^CNT_W), PC<=next_pc -> FETCH.
  - Req for the new PC is asserted in the cycle after ack.
- next_pc, with pc4 = PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0):
  - Jump=1: {pc4[31:28], Instr[25:0], 2'b00}. Jump has priority over Branch; the J encoding drives both high.
  - else Branch=1 and BrTaken=1: pc4 + (sign-extended Instr[15:0] << 2), 32-bit wrap.
  - else: pc4.
  - BrTaken ignored when Branch=0.
- Ignored inputs, no effect:
  - instr_ack outside HOLD.
  - imem_ready outside FETCH.
  - Branch/Jump/BrTaken when instr_ack=0.
- OpCode/Funct are combinational slices of Instr. Reset Instr=0 decodes as SLL $0 (NOP).
- Latency: ack at cycle t -> imem_req=1 with new address at t+1 -> earliest instr_valid at t+2.
- PC is always word aligned; bits [1:0] are 0 by construction.

Test Plan:
- Reset/boot: rst_n low 3 cycles, release, imem_ready tied 1 -> cycle 1 after release imem_req=0; cycle 2 imem_req=1, imem_addr=32'h3000; cycle 3 instr_valid=1.
- Sequential with wait states: ready delayed 3 cycles, rdata=32'h0000_0020 (ADD) -> req/addr stable during wait, Instr=32'h20, Funct=6'h20; ack -> next addr 32'h3004, fetch_cnt=1.
- Branch taken/not taken: PC=32'h3008, Instr imm=16'hFFFE, Branch=1. BrTaken=1 -> next addr 32'h3004; BrTaken=0 -> 32'h300C.
- Jump priority: PC=32'h3010, Instr=32'h0800_0C00, Jump=1, Branch=1, BrTaken=0 -> next addr 32'h0000_3000.
- Wrap: force PC=32'hFFFF_FFFC, sequential ack -> addr 0. Run 2^CNT_W acks -> fetch_cnt returns to 0.
- Reset mid-fetch and stray inputs: assert rst_n=0 while imem_req=1 -> imem_req, instr_valid drop the same cycle. instr_ack pulsed in FETCH -> PC unchanged.
